// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the single-port FIFO command path.
//   DW, DEPTH     default data width and FIFO capacity
//   WE_BIT/RE_BIT bit positions of the write/read enables inside inst
//   inst_t        packed {WE, RE, DI} command word for the default width
package fifo_pkg;
   localparam int unsigned DW     = 32;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned WE_BIT = DW + 1;
   localparam int unsigned RE_BIT = DW;

   typedef logic [DW+1:0] inst_t;
endpackage

// File: rtl/cmd_ret_buf.sv
// cmd_ret_buf: circular buffer holding FIFO read data until the consumer
// takes it.
//   clk, rst   clock; synchronous active-low reset
//   push       write push_data at the tail (caller guarantees space)
//   push_data  data to store
//   pop        remove the head entry (ignored when empty)
//   occ        number of entries held
//   head       data at the head of the buffer
module cmd_ret_buf #(
   parameter int unsigned DW        = 32,
   parameter int unsigned RET_DEPTH = 2,
   localparam int unsigned OW       = $clog2(RET_DEPTH + 1),
   localparam int unsigned PW       = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [OW-1:0] occ,
   output logic [DW-1:0] head
);
   import fifo_pkg::*;

   logic [DW-1:0] mem [RET_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(RET_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop = pop && (occ != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         for (int unsigned i = 0; i < RET_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         occ <= occ + OW'(push) - OW'(do_pop);
      end
   end
endmodule

// File: rtl/fifo_cmd_issuer.sv
// fifo_cmd_issuer: turns a write stream and a read-request stream into the
// registered {WE, RE, DI} command word for the single-port FIFO, tracks
// occupancy so the FIFO never over/underflows, and returns read data
// through a credit-protected buffer.
//   clk, rst                         clock; synchronous active-low reset
//   wr_valid/wr_ready/wr_data        write stream
//   rd_valid/rd_ready                read-request stream
//   inst                             registered {WE, RE, DI} to the FIFO
//   res/read_valid                   FIFO read data and strobe
//   out_valid/out_ready/out_data     returned-data stream
//   count                            tracked FIFO occupancy
//   err                              sticky: read_valid with no read pending
// Optional: define FIFO_ISSUER_STATS_EN to add saturating 16-bit counters
//   stat_wr, stat_rd (fires) and stat_stall (cycles with a blocked valid).
module fifo_cmd_issuer #(
   parameter int unsigned DW        = fifo_pkg::DW,
   parameter int unsigned DEPTH     = fifo_pkg::DEPTH,
   parameter int unsigned RET_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [DW-1:0]                wr_data,
   input  logic                         rd_valid,
   output logic                         rd_ready,
   output logic [DW+1:0]                inst,
   input  logic [DW-1:0]                res,
   input  logic                         read_valid,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DW-1:0]                out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         err
`ifdef FIFO_ISSUER_STATS_EN
   ,
   output logic [15:0]                  stat_wr,
   output logic [15:0]                  stat_rd,
   output logic [15:0]                  stat_stall
`endif
);
   import fifo_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = $clog2(RET_DEPTH + 1);

   logic [OW-1:0] outstanding;
   logic [OW-1:0] ret_occ;
   logic [OW-1:0] credit;
   logic          fw;
   logic          fr;
   logic          rv_ok;
   logic          rv_bad;

   // Every return-buffer slot is either filled or promised to an issued
   // read; a read may only issue while an unpromised slot remains.
   assign credit   = OW'(RET_DEPTH) - ret_occ - outstanding;
   assign wr_ready = (count < CW'(DEPTH));
   assign rd_ready = (count != '0) && (credit != '0);
   assign fw       = wr_valid && wr_ready;
   assign fr       = rd_valid && rd_ready;
   assign rv_ok    = read_valid && (outstanding != '0);
   assign rv_bad   = read_valid && (outstanding == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         inst        <= '0;
         count       <= '0;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         inst        <= {fw, fr, fw ? wr_data : inst[DW-1:0]};
         count       <= count + CW'(fw) - CW'(fr);
         outstanding <= outstanding + OW'(fr) - OW'(rv_ok);
         if (rv_bad) err <= 1'b1;
      end
   end

   cmd_ret_buf #(
      .DW        (DW),
      .RET_DEPTH (RET_DEPTH)
   ) u_ret_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (rv_ok),
      .push_data (res),
      .pop       (out_valid && out_ready),
      .occ       (ret_occ),
      .head      (out_data)
   );

   assign out_valid = (ret_occ != '0);

`ifdef FIFO_ISSUER_STATS_EN
   logic stall;
   assign stall = (wr_valid && !wr_ready) || (rd_valid && !rd_ready);

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_wr    <= '0;
         stat_rd    <= '0;
         stat_stall <= '0;
      end else begin
         if (fw && (stat_wr != '1))       stat_wr    <= stat_wr + 16'd1;
         if (fr && (stat_rd != '1))       stat_rd    <= stat_rd + 16'd1;
         if (stall && (stat_stall != '1)) stat_stall <= stat_stall + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fifo_cmd_issuer.sv
module tb_fifo_cmd_issuer;
   import fifo_pkg::*;

   localparam int unsigned RD = 2;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW+1:0] inst;
   logic [DW-1:0] res;
   logic          read_valid;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] count;
   logic          err;
`ifdef FIFO_ISSUER_STATS_EN
   logic [15:0]   stat_wr;
   logic [15:0]   stat_rd;
   logic [15:0]   stat_stall;
`endif

   fifo_cmd_issuer #(
      .DW        (DW),
      .DEPTH     (DEPTH),
      .RET_DEPTH (RD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .inst       (inst),
      .res        (res),
      .read_valid (read_valid),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .count      (count),
      .err        (err)
`ifdef FIFO_ISSUER_STATS_EN
      ,
      .stat_wr    (stat_wr),
      .stat_rd    (stat_rd),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_bad = 0;

   // Reference model: issuer state plus the downstream FIFO contents.
   int            m_count;
   int            m_out;
   logic          m_err;
   logic [DW-1:0] m_di;
   logic [DW-1:0] m_fifo[$];
   logic [DW-1:0] m_pend[$];
   logic [DW-1:0] m_ret[$];
   inst_t         exp_inst[$];
   inst_t         ev;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_count = 0;
      m_out   = 0;
      m_err   = 1'b0;
      m_di    = '0;
      m_fifo.delete();
      m_pend.delete();
      m_ret.delete();
      exp_inst.delete();
   endtask

   task automatic idle_inputs();
      wr_valid   = 1'b0;
      wr_data    = '0;
      rd_valid   = 1'b0;
      res        = '0;
      read_valid = 1'b0;
      out_ready  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      tick();
      rst = 1'b1;
      model_clear();
   endtask

   // Advance one clock: predict this edge from the current inputs, queue the
   // expected command word, then clock the DUT.
   task automatic cycle();
      logic mwr, mrd, fw, fr, good;
      mwr  = (m_count < int'(DEPTH));
      mrd  = (m_count != 0) && ((int'(RD) - int'(m_ret.size()) - m_out) != 0);
      fw   = wr_valid && mwr;
      fr   = rd_valid && mrd;
      good = read_valid && (m_out != 0);
      if (fw) m_di = wr_data;
      exp_inst.push_back({fw, fr, m_di});
      if (read_valid && (m_out == 0)) m_err = 1'b1;
      if (out_ready && (m_ret.size() != 0)) void'(m_ret.pop_front());
      if (good) m_ret.push_back(res);
      if (fw) m_fifo.push_back(wr_data);
      if (fr) m_pend.push_back(m_fifo.pop_front());
      m_count = m_count + int'(fw) - int'(fr);
      m_out   = m_out + int'(fr) - int'(good);
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      wr_valid = 1'b1;
      wr_data  = 32'hDEAD_BEEF;
      tick();
      tick();
      n_vec++; if (inst !== '0)      begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
      n_vec++; if (count !== '0)     begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if (out_valid !== 0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (out_data !== '0)  begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_vec++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      n_vec++; if (wr_ready !== 1)   begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
      n_vec++; if (rd_ready !== 0)   begin n_bad++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
      idle_inputs();
      rst = 1'b1;
      model_clear();
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         wr_valid = 1'b1;
         wr_data  = DW'(i);
         n_vec++;
         if (wr_ready !== 1'(i <= 8)) begin n_bad++; $display("FAIL fill_wr_ready[%0d]: got %b want %b", i, wr_ready, (i <= 8)); end
         cycle();
         ev = exp_inst.pop_front();
         n_vec++; if (inst !== ev) begin n_bad++; $display("FAIL fill_inst[%0d]: got %h want %h", i, inst, ev); end
      end
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev)                  begin n_bad++; $display("FAIL full_hold_inst: got %h want %h", inst, ev); end
      n_vec++; if (inst !== {2'b00, 32'd8})      begin n_bad++; $display("FAIL full_hold_di: got %h want 0_0_8", inst); end
      n_vec++; if (count !== CW'(8))             begin n_bad++; $display("FAIL full_count: got %0d want 8", count); end
      n_vec++; if (wr_ready !== 1'b0)            begin n_bad++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
   endtask

   // Continues from the full state left by test_fill_full (9 still pending).
   task automatic test_simul_full();
      rd_valid  = 1'b1;
      out_ready = 1'b1;
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev)             begin n_bad++; $display("FAIL simul_c1_inst: got %h want %h", inst, ev); end
      n_vec++; if (inst !== {2'b01, 32'd8}) begin n_bad++; $display("FAIL simul_c1_const: got %h want 1_8 (RE only)", inst); end
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev)             begin n_bad++; $display("FAIL simul_c2_inst: got %h want %h", inst, ev); end
      n_vec++; if (inst[WE_BIT] !== 1'b1 || inst[RE_BIT] !== 1'b1)
         begin n_bad++; $display("FAIL simul_c2_we_re: got %b%b want 11", inst[WE_BIT], inst[RE_BIT]); end
      n_vec++; if (count !== CW'(m_count))  begin n_bad++; $display("FAIL simul_count: got %0d want %0d", count, m_count); end
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         read_valid = (m_pend.size() != 0);
         res        = (m_pend.size() != 0) ? m_pend.pop_front() : '0;
         cycle();
         ev = exp_inst.pop_front();
         n_vec++; if (inst !== ev) begin n_bad++; $display("FAIL simul_ret_inst[%0d]: got %h want %h", k, inst, ev); end
         n_vec++; if (out_valid !== (m_ret.size() != 0))
            begin n_bad++; $display("FAIL simul_out_valid[%0d]: got %b want %b", k, out_valid, (m_ret.size() != 0)); end
         if (m_ret.size() != 0) begin
            n_vec++; if (out_data !== m_ret[0]) begin n_bad++; $display("FAIL simul_out_data[%0d]: got %h want %h", k, out_data, m_ret[0]); end
         end
      end
      read_valid = 1'b0;
   endtask

   task automatic test_read_empty();
      do_reset();
      rd_valid  = 1'b1;
      out_ready = 1'b1;
      n_vec++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL empty_rd_ready: got %b want 0", rd_ready); end
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev) begin n_bad++; $display("FAIL empty_idle_inst: got %h want %h", inst, ev); end
      wr_valid = 1'b1;
      wr_data  = 32'd5;
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev || inst !== {2'b10, 32'd5}) begin n_bad++; $display("FAIL empty_write_inst: got %h want %h", inst, ev); end
      wr_valid = 1'b0;
      n_vec++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL empty_rd_ready_after_wr: got %b want 1", rd_ready); end
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev || inst !== {2'b01, 32'd5}) begin n_bad++; $display("FAIL empty_read_inst: got %h want %h", inst, ev); end
      n_vec++; if (count !== '0) begin n_bad++; $display("FAIL empty_count: got %0d want 0", count); end
      rd_valid   = 1'b0;
      read_valid = 1'b1;
      res        = m_pend.pop_front();
      cycle();
      void'(exp_inst.pop_front());
      read_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_data !== 32'd5)
         begin n_bad++; $display("FAIL empty_return: got v=%b d=%h want v=1 d=5", out_valid, out_data); end
   endtask

   task automatic test_ret_backpressure();
      int re_seen;
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         wr_valid = 1'b1;
         wr_data  = DW'(i);
         cycle();
         ev = exp_inst.pop_front();
         n_vec++; if (inst !== ev) begin n_bad++; $display("FAIL bp_wr_inst[%0d]: got %h want %h", i, inst, ev); end
      end
      wr_valid = 1'b0;
      rd_valid = 1'b1;
      re_seen  = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         ev = exp_inst.pop_front();
         n_vec++; if (inst !== ev) begin n_bad++; $display("FAIL bp_rd_inst[%0d]: got %h want %h", k, inst, ev); end
         re_seen += int'(inst[RE_BIT]);
      end
      n_vec++; if (re_seen !== 2)     begin n_bad++; $display("FAIL bp_re_count: got %0d want 2", re_seen); end
      n_vec++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rd_ready_blocked: got %b want 0", rd_ready); end
      for (int k = 0; k < 2; k++) begin
         read_valid = 1'b1;
         res        = m_pend.pop_front();
         cycle();
         void'(exp_inst.pop_front());
      end
      read_valid = 1'b0;
      n_vec++; if (rd_ready !== 1'b0)     begin n_bad++; $display("FAIL bp_rd_ready_full_buf: got %b want 0", rd_ready); end
      n_vec++; if (out_data !== 32'd1)    begin n_bad++; $display("FAIL bp_order_1: got %h want 1", out_data); end
      out_ready = 1'b1;
      cycle();
      void'(exp_inst.pop_front());
      out_ready = 1'b0;
      n_vec++; if (rd_ready !== 1'b1)     begin n_bad++; $display("FAIL bp_rd_ready_freed: got %b want 1", rd_ready); end
      cycle();
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev || inst !== {2'b01, 32'd3}) begin n_bad++; $display("FAIL bp_third_re: got %h want %h", inst, ev); end
      rd_valid   = 1'b0;
      read_valid = 1'b1;
      res        = m_pend.pop_front();
      cycle();
      void'(exp_inst.pop_front());
      read_valid = 1'b0;
      out_ready  = 1'b1;
      n_vec++; if (out_data !== 32'd2)    begin n_bad++; $display("FAIL bp_order_2: got %h want 2", out_data); end
      cycle();
      void'(exp_inst.pop_front());
      n_vec++; if (out_data !== 32'd3 || out_valid !== 1'b1)
         begin n_bad++; $display("FAIL bp_order_3: got v=%b d=%h want v=1 d=3", out_valid, out_data); end
      cycle();
      void'(exp_inst.pop_front());
      n_vec++; if (out_valid !== 1'b0)    begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_spurious();
      do_reset();
      wr_valid = 1'b1;
      wr_data  = 32'd7;
      cycle();
      void'(exp_inst.pop_front());
      wr_valid   = 1'b0;
      read_valid = 1'b1;
      res        = 32'hBAD0_0BAD;
      cycle();
      void'(exp_inst.pop_front());
      read_valid = 1'b0;
      n_vec++; if (err !== 1'b1)        begin n_bad++; $display("FAIL spur_err: got %b want 1", err); end
      n_vec++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL spur_out_valid: got %b want 0", out_valid); end
      n_vec++; if (count !== CW'(1))    begin n_bad++; $display("FAIL spur_count: got %0d want 1", count); end
      n_vec++; if (rd_ready !== 1'b1)   begin n_bad++; $display("FAIL spur_credit: got rd_ready=%b want 1", rd_ready); end
      cycle();
      void'(exp_inst.pop_front());
      n_vec++; if (err !== m_err)       begin n_bad++; $display("FAIL spur_sticky: got %b want %b", err, m_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = DW'(i);
         cycle();
         void'(exp_inst.pop_front());
      end
      wr_valid = 1'b0;
      rd_valid = 1'b1;
      cycle();
      void'(exp_inst.pop_front());
      rd_valid = 1'b0;
      n_vec++; if (count !== CW'(4)) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 4", count); end
      rst = 1'b0;
      idle_inputs();
      tick();
      n_vec++; if (inst !== '0 || count !== '0 || out_valid !== 1'b0 || out_data !== '0 || err !== 1'b0)
         begin n_bad++; $display("FAIL mid_reset_outputs: got inst=%h count=%0d ov=%b od=%h err=%b want all 0", inst, count, out_valid, out_data, err); end
      n_vec++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rd_ready: got %b want 0", rd_ready); end
      rst = 1'b1;
      model_clear();
      wr_valid = 1'b1;
      wr_data  = 32'hA;
      cycle();
      wr_valid = 1'b0;
      ev = exp_inst.pop_front();
      n_vec++; if (inst !== ev || inst !== {2'b10, 32'hA}) begin n_bad++; $display("FAIL mid_after_write: got %h want %h", inst, ev); end
      n_vec++; if (count !== CW'(1)) begin n_bad++; $display("FAIL mid_after_count: got %0d want 1", count); end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      model_clear();
      test_reset();
      test_fill_full();
      test_simul_full();
      test_read_empty();
      test_ret_backpressure();
      test_spurious();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
